// File: rtl/if_id_redirect_unit.sv
// IF/ID register plus ID-stage branch/jump resolution; redirect controls are combinational, IF/ID updates each edge.
// iStall holds PC and IF/ID and masks redirects; REDIRECT_STATS_EN adds a saturating redirect counter.
module if_id_redirect_unit #(
   parameter logic [31:0] NOP_WORD      = 32'h0000_0000,
   parameter logic [31:0] RESET_PCPLUS4 = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] iPCPlus4,
   input  logic [31:0] iInstruction,
   input  logic [31:0] iRsData,
   input  logic [31:0] iRtData,
   input  logic        iStall,
   output logic        oPCWrite,
   output logic        oPCSrc,
   output logic        oPCMux,
   output logic [31:0] oPCSumImm,
   output logic [31:0] oReadReg1,
   output logic [31:0] oIFIDPCPlus4,
   output logic [31:0] oIFIDInstruction,
   output logic        oState
`ifdef REDIRECT_STATS_EN
  ,output logic [15:0] oRedirectCount
`endif
);

   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] SQUASH = 1'b1;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;

   typedef struct packed {
      logic [31:0] pcPlus4;
      logic [31:0] instruction;
   } ifIdReg_t;

   ifIdReg_t   ifId;
   logic [0:0] state;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic        regsEqual;
   logic        isBranchTaken;
   logic        isJump;
   logic        isJr;
   logic        canRedirect;
   logic        takeSum;
   logic        takeReg;
   logic        redirect;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;

   assign op    = ifId.instruction[31:26];
   assign funct = ifId.instruction[5:0];
   assign imm   = ifId.instruction[15:0];

   assign regsEqual     = (iRsData == iRtData);
   assign isBranchTaken = ((op == OP_BEQ) && regsEqual) || ((op == OP_BNE) && !regsEqual);
   assign isJump        = (op == OP_J) || (op == OP_JAL);
   assign isJr          = (op == OP_SPECIAL) && (funct == FUNCT_JR);

   assign branchTarget = ifId.pcPlus4 + {{14{imm[15]}}, imm, 2'b00};
   assign jumpTarget   = {ifId.pcPlus4[31:28], ifId.instruction[25:0], 2'b00};

   // The bubble held during SQUASH must never redirect, whatever NOP_WORD decodes to.
   assign canRedirect = (state == RUN) && !Reset;
   assign takeSum     = canRedirect && (isBranchTaken || isJump);
   assign takeReg     = canRedirect && isJr;
   assign redirect    = (takeSum || takeReg) && !iStall;

   assign oPCWrite  = Reset || !iStall;
   assign oPCSrc    = takeSum && !iStall;
   assign oPCMux    = takeReg && !iStall;
   assign oPCSumImm = !takeSum ? 32'h0000_0000 : (isJump ? jumpTarget : branchTarget);
   assign oReadReg1 = iRsData;

   assign oIFIDPCPlus4     = ifId.pcPlus4;
   assign oIFIDInstruction = ifId.instruction;
   assign oState           = state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ifId  <= '{pcPlus4: RESET_PCPLUS4, instruction: NOP_WORD};
         state <= RUN;
      end else if (iStall) begin
         ifId  <= ifId;
         state <= state;
      end else if (redirect) begin
         ifId  <= '{pcPlus4: iPCPlus4, instruction: NOP_WORD};
         state <= SQUASH;
      end else begin
         ifId  <= '{pcPlus4: iPCPlus4, instruction: iInstruction};
         state <= RUN;
      end
   end

`ifdef REDIRECT_STATS_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         oRedirectCount <= 16'h0000;
      end else if (redirect && (oRedirectCount != 16'hFFFF)) begin
         oRedirectCount <= oRedirectCount + 16'h0001;
      end
   end
`endif

endmodule
